pipelined_sum_unit: RTL and testbench

//   Parametrised successor to the single-cycle add/sum method block. Accepts operand pairs plus carry-in

---
 rtl/pipelined_sum_pkg.sv | 19 +
 rtl/sum_result_fifo.sv | 73 +++++++
 rtl/pipelined_sum_unit.sv | 139 +++++++++++++
 tb/tb_pipelined_sum_unit.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipelined_sum_pkg.sv
// Shared types and sizing helpers for the pipelined adder and its result FIFO.
package pipelined_sum_pkg;

  localparam int unsigned DEF_WIDTH = 32;
  localparam int unsigned DEF_CHUNK = 8;
  localparam int unsigned DEF_DEPTH = 4;
  localparam int unsigned STAGES    = DEF_WIDTH / DEF_CHUNK;

  typedef struct packed {
    logic [DEF_WIDTH-1:0] sum;
    logic                 cry;
  } result_t;

  // Bits needed to hold an occupancy value in the range 0..depth.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/sum_result_fifo.sv
// Shift-register result FIFO: entry 0 is always the head, so the head output is a plain register.
// Flush and reset empty it in one cycle; the head reads as zero whenever the FIFO is empty.
module sum_result_fifo
  import pipelined_sum_pkg::*;
#(
  parameter int unsigned DEPTH  = DEF_DEPTH,
  parameter type         ITEM_T = result_t,
  localparam int unsigned CW    = cnt_width(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_flush,
  input  logic          i_push,
  input  ITEM_T         i_data,
  input  logic          i_pop,
  output ITEM_T         o_head,
  output logic          o_full,
  output logic          o_empty,
  output logic [CW-1:0] o_count
);

  ITEM_T         r_mem   [DEPTH];
  ITEM_T         w_mem_d [DEPTH];
  logic [CW-1:0] r_count;
  logic [CW-1:0] w_count_d;
  logic          w_pop;
  logic          w_push;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == CW'(DEPTH));
  assign o_count = r_count;
  assign o_head  = o_empty ? '0 : r_mem[0];

  assign w_pop  = i_pop & ~o_empty;
  assign w_push = i_push & (~o_full | w_pop);

  always_comb begin
    w_count_d = r_count;
    for (int i = 0; i < DEPTH; i++) begin
      w_mem_d[i] = r_mem[i];
    end
    if (w_pop) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        w_mem_d[i] = r_mem[i + 1];
      end
      w_count_d = w_count_d - 1'b1;
    end
    // Write slot is the first free entry after any same-cycle shift.
    if (w_push) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (CW'(i) == w_count_d) begin
          w_mem_d[i] = i_data;
        end
      end
      w_count_d = w_count_d + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      r_count <= '0;
    end else begin
      r_count <= w_count_d;
    end
  end

  always_ff @(posedge i_clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      r_mem[i] <= w_mem_d[i];
    end
  end

endmodule

// File: rtl/pipelined_sum_unit.sv
// Pipelined adder: CHUNK-bit carry stages feeding a credit-limited result FIFO.
// Method-style handshake: RDY_* advertise readiness, EN_* fire the action.
module pipelined_sum_unit
  import pipelined_sum_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned CHUNK = DEF_CHUNK,
  parameter int unsigned DEPTH = DEF_DEPTH,
  localparam int unsigned CW   = cnt_width(DEPTH)
) (
  input  logic             CLK,
  input  logic             RST,
  output logic             RDY_add,
  input  logic             EN_add,
  input  logic [WIDTH-1:0] add_s_a,
  input  logic [WIDTH-1:0] add_s_b,
  input  logic             add_cin,
  output logic             RDY_sum,
  input  logic             EN_sum,
  output logic [WIDTH-1:0] sum_sum,
  output logic             sum_cry,
  input  logic             EN_clear,
  output logic [CW-1:0]    count
);

  localparam int unsigned PIPE_STAGES = WIDTH / CHUNK;
  localparam int unsigned LAST        = PIPE_STAGES - 1;
  localparam int unsigned NREG        = (PIPE_STAGES > 1) ? PIPE_STAGES - 1 : 1;

  typedef struct packed {
    logic [WIDTH-1:0] sum;
    logic             cry;
  } res_t;

  // Stage-input view: index 0 is the add port, index k>0 is pipeline register k-1.
  logic [WIDTH-1:0] w_a    [PIPE_STAGES];
  logic [WIDTH-1:0] w_b    [PIPE_STAGES];
  logic [WIDTH-1:0] w_psum [PIPE_STAGES];
  logic             w_cin  [PIPE_STAGES];
  logic             w_vld  [PIPE_STAGES];
  logic [WIDTH-1:0] w_nsum [PIPE_STAGES];
  logic             w_ncry [PIPE_STAGES];

  logic [WIDTH-1:0] r_a    [NREG];
  logic [WIDTH-1:0] r_b    [NREG];
  logic [WIDTH-1:0] r_psum [NREG];
  logic             r_cry  [NREG];
  logic             r_vld  [NREG];

  logic          w_add_fire;
  logic          w_push;
  logic          w_pop;
  logic          w_fifo_full;
  logic          w_fifo_empty;
  logic [CW-1:0] w_fifo_cnt;
  int unsigned   w_occ;
  res_t          w_push_data;
  res_t          w_head;

  assign w_add_fire = EN_add & RDY_add & ~EN_clear;

  for (genvar k = 0; k < PIPE_STAGES; k++) begin : g_stage
    logic [CHUNK:0] w_chunk;

    if (k == 0) begin : g_in
      assign w_a[k]    = add_s_a;
      assign w_b[k]    = add_s_b;
      assign w_psum[k] = '0;
      assign w_cin[k]  = add_cin;
      assign w_vld[k]  = w_add_fire;
    end else begin : g_reg
      assign w_a[k]    = r_a[k-1];
      assign w_b[k]    = r_b[k-1];
      assign w_psum[k] = r_psum[k-1];
      assign w_cin[k]  = r_cry[k-1];
      assign w_vld[k]  = r_vld[k-1];
    end

    assign w_chunk = {1'b0, w_a[k][k*CHUNK +: CHUNK]} + {1'b0, w_b[k][k*CHUNK +: CHUNK]}
                   + {{CHUNK{1'b0}}, w_cin[k]};
    // Chunks above k are still zero in the partial sum, so OR-ing in is enough.
    assign w_nsum[k] = w_psum[k] | (WIDTH'(w_chunk[CHUNK-1:0]) << (k * CHUNK));
    assign w_ncry[k] = w_chunk[CHUNK];
  end

  always_ff @(posedge CLK) begin
    for (int k = 0; k < int'(LAST); k++) begin
      r_vld[k]  <= (RST || EN_clear) ? 1'b0 : w_vld[k];
      r_a[k]    <= w_a[k];
      r_b[k]    <= w_b[k];
      r_psum[k] <= w_nsum[k];
      r_cry[k]  <= w_ncry[k];
    end
  end

  // The final stage writes straight into the FIFO; credits guarantee room.
  assign w_push      = w_vld[LAST] & ~EN_clear;
  assign w_push_data = {w_nsum[LAST], w_ncry[LAST]};
  assign w_pop       = EN_sum & ~EN_clear;

  sum_result_fifo #(
    .DEPTH  (DEPTH),
    .ITEM_T (res_t)
  ) u_fifo (
    .i_clk   (CLK),
    .i_rst   (RST),
    .i_flush (EN_clear),
    .i_push  (w_push),
    .i_data  (w_push_data),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_count (w_fifo_cnt)
  );

  // Occupancy counts only registered state, so a same-cycle dequeue never bypasses to RDY_add.
  always_comb begin
    w_occ = 32'(w_fifo_cnt);
    for (int k = 0; k < int'(LAST); k++) begin
      w_occ = w_occ + 32'(r_vld[k]);
    end
  end

  assign RDY_add = (w_occ < DEPTH);
  assign count   = CW'(w_occ);
  assign RDY_sum = ~w_fifo_empty;
  assign sum_sum = w_head.sum;
  assign sum_cry = w_head.cry;

  a_add_rdy: assert property (@(posedge CLK) disable iff (RST) (EN_add && !EN_clear) |-> RDY_add)
    else $warning("EN_add while RDY_add low; request ignored");
  a_sum_rdy: assert property (@(posedge CLK) disable iff (RST) (EN_sum && !EN_clear) |-> RDY_sum)
    else $warning("EN_sum while RDY_sum low; request ignored");
  a_no_overflow: assert property (@(posedge CLK) disable iff (RST)
                                  w_push |-> (!w_fifo_full || (w_pop && !w_fifo_empty)))
    else $error("result FIFO overflow");

endmodule

// File: tb/tb_pipelined_sum_unit.sv
// Randomized and directed bench for two pipelined_sum_unit configurations (4 stages/depth 4 and
// 1 stage/depth 1), each compared cycle by cycle against a queue-based transaction model.
module tb_pipelined_sum_unit;

  localparam int W = 32;

  typedef struct {
    logic [W:0] res;
    int         due;
  } item_t;

  logic         clk = 1'b0;
  logic         rst;
  logic [1:0]   en_add, en_sum, en_clr, cin;
  logic [W-1:0] a     [2];
  logic [W-1:0] b     [2];
  logic [1:0]   rdy_add, rdy_sum, cry;
  logic [W-1:0] sum_o [2];
  logic [2:0]   cnt0;
  logic [0:0]   cnt1;

  item_t      pipe_q [2][$];
  logic [W:0] fifo_q [2][$];
  int         cyc;
  int         n_chk;
  int         n_err;

  always #5 clk = ~clk;

  pipelined_sum_unit #(.WIDTH(32), .CHUNK(8), .DEPTH(4)) u_dut0 (
    .CLK(clk), .RST(rst), .RDY_add(rdy_add[0]), .EN_add(en_add[0]), .add_s_a(a[0]),
    .add_s_b(b[0]), .add_cin(cin[0]), .RDY_sum(rdy_sum[0]), .EN_sum(en_sum[0]),
    .sum_sum(sum_o[0]), .sum_cry(cry[0]), .EN_clear(en_clr[0]), .count(cnt0)
  );

  pipelined_sum_unit #(.WIDTH(32), .CHUNK(32), .DEPTH(1)) u_dut1 (
    .CLK(clk), .RST(rst), .RDY_add(rdy_add[1]), .EN_add(en_add[1]), .add_s_a(a[1]),
    .add_s_b(b[1]), .add_cin(cin[1]), .RDY_sum(rdy_sum[1]), .EN_sum(en_sum[1]),
    .sum_sum(sum_o[1]), .sum_cry(cry[1]), .EN_clear(en_clr[1]), .count(cnt1)
  );

  function automatic int stg(input int i);
    return (i == 0) ? 4 : 1;
  endfunction

  function automatic int dep(input int i);
    return (i == 0) ? 4 : 1;
  endfunction

  function automatic logic [63:0] cnt_of(input int i);
    return (i == 0) ? 64'(cnt0) : 64'(cnt1);
  endfunction

  function automatic string tg(input int i, input string s);
    return $sformatf("u%0d_%s", i, s);
  endfunction

  function automatic bit can_add(input int i);
    return (pipe_q[i].size() + fifo_q[i].size()) < dep(i);
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Transaction model: a result becomes visible STAGES-1 edges after the accepting edge.
  task automatic model_step(input int i);
    bit    ok_add;
    bit    ok_sum;
    item_t it;
    ok_add = can_add(i);
    ok_sum = fifo_q[i].size() > 0;
    if (rst || en_clr[i]) begin
      pipe_q[i].delete();
      fifo_q[i].delete();
      return;
    end
    if (en_sum[i] && ok_sum) void'(fifo_q[i].pop_front());
    if (en_add[i] && ok_add) begin
      it.res = {1'b0, a[i]} + {1'b0, b[i]} + {{W{1'b0}}, cin[i]};
      it.due = cyc + stg(i) - 1;
      pipe_q[i].push_back(it);
    end
    while (pipe_q[i].size() > 0 && pipe_q[i][0].due <= cyc) begin
      it = pipe_q[i].pop_front();
      fifo_q[i].push_back(it.res);
    end
  endtask

  task automatic check_outputs(input int i);
    logic [W:0] h;
    int         occ;
    occ = pipe_q[i].size() + fifo_q[i].size();
    h   = (fifo_q[i].size() > 0) ? fifo_q[i][0] : '0;
    check(tg(i, "rdy_add"), rdy_add[i], 64'(occ < dep(i)));
    check(tg(i, "rdy_sum"), rdy_sum[i], 64'(fifo_q[i].size() > 0));
    check(tg(i, "count"), cnt_of(i), 64'(occ));
    check(tg(i, "sum"), sum_o[i], 64'(h[W-1:0]));
    check(tg(i, "cry"), cry[i], 64'(h[W]));
  endtask

  task automatic tick();
    for (int i = 0; i < 2; i++) model_step(i);
    cyc++;
    @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 2; i++) check_outputs(i);
  endtask

  task automatic idle();
    en_add = '0;
    en_sum = '0;
    en_clr = '0;
    cin    = '0;
    for (int i = 0; i < 2; i++) begin
      a[i] = '0;
      b[i] = '0;
    end
  endtask

  task automatic set_add(input int i, input logic [W-1:0] av, input logic [W-1:0] bv,
                         input logic c);
    en_add[i] = 1'b1;
    a[i]      = av;
    b[i]      = bv;
    cin[i]    = c;
  endtask

  task automatic single(input int i, input string nm, input logic [W-1:0] av,
                        input logic [W-1:0] bv, input logic c, input logic [W-1:0] es,
                        input logic ec);
    idle();
    set_add(i, av, bv, c);
    tick();
    idle();
    repeat (stg(i) - 1) tick();
    check(tg(i, {nm, "_rdy"}), rdy_sum[i], 64'd1);
    check(tg(i, {nm, "_sum"}), sum_o[i], 64'(es));
    check(tg(i, {nm, "_cry"}), cry[i], 64'(ec));
    en_sum[i] = 1'b1;
    tick();
    idle();
  endtask

  task automatic drain(input int i);
    idle();
    for (int n = 0; n < 16 && (pipe_q[i].size() + fifo_q[i].size()) > 0; n++) begin
      en_sum[i] = fifo_q[i].size() > 0;
      tick();
    end
    idle();
    check(tg(i, "drained"), cnt_of(i), 64'd0);
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    cyc   = 0;
    rst   = 1'b1;
    idle();
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      check(tg(i, "rst_rdy_add"), rdy_add[i], 64'd1);
      check(tg(i, "rst_rdy_sum"), rdy_sum[i], 64'd0);
      check(tg(i, "rst_count"), cnt_of(i), 64'd0);
    end

    for (int i = 0; i < 2; i++) begin
      // Carry ripples across every chunk boundary.
      single(i, "t1", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1);
      single(i, "t2a", 32'h0000_00FF, 32'h0000_0001, 1'b1, 32'h0000_0101, 1'b0);
      single(i, "t2b", 32'h8000_0000, 32'h8000_0000, 1'b1, 32'h0000_0001, 1'b1);

      // One more add than credits allow; the last one must be dropped.
      for (int n = 0; n <= dep(i); n++) begin
        idle();
        set_add(i, $urandom, $urandom, 1'($urandom_range(1)));
        tick();
      end
      idle();
      check(tg(i, "t3_rdy_add"), rdy_add[i], 64'd0);
      check(tg(i, "t3_count"), cnt_of(i), 64'(dep(i)));
      repeat (stg(i)) tick();
      drain(i);

      // Streaming with add and dequeue asserted together.
      for (int n = 0; n < 24; n++) begin
        idle();
        if (can_add(i)) set_add(i, $urandom, $urandom, 1'($urandom_range(1)));
        en_sum[i] = fifo_q[i].size() > 0;
        tick();
      end
      drain(i);

      // Results both in flight and buffered, then a flush with a colliding add.
      for (int p = 0; p < 2; p++) begin
        for (int n = 0; n < 2; n++) begin
          idle();
          if (can_add(i)) set_add(i, $urandom, $urandom, 1'b1);
          tick();
        end
        idle();
        if (p == 0) repeat (stg(i) - 1) tick();
      end
      set_add(i, $urandom, $urandom, 1'b0);
      en_sum[i] = 1'b1;
      en_clr[i] = 1'b1;
      tick();
      idle();
      check(tg(i, "t5_count"), cnt_of(i), 64'd0);
      check(tg(i, "t5_rdy_sum"), rdy_sum[i], 64'd0);
      check(tg(i, "t5_rdy_add"), rdy_add[i], 64'd1);
      for (int n = 0; n < 8; n++) begin
        tick();
        check(tg(i, "t5_quiet"), rdy_sum[i], 64'd0);
      end
    end

    // Reset in the middle of traffic.
    for (int n = 0; n < 6; n++) begin
      idle();
      for (int i = 0; i < 2; i++) begin
        if (can_add(i)) set_add(i, $urandom, $urandom, 1'($urandom_range(1)));
      end
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    idle();
    for (int i = 0; i < 2; i++) begin
      check(tg(i, "t6_rdy_add"), rdy_add[i], 64'd1);
      check(tg(i, "t6_rdy_sum"), rdy_sum[i], 64'd0);
      check(tg(i, "t6_count"), cnt_of(i), 64'd0);
      check(tg(i, "t6_sum"), sum_o[i], 64'd0);
    end
    repeat (6) tick();

    // Random traffic with carry-heavy operands and occasional flushes.
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < 2; i++) begin
        en_add[i] = ($urandom_range(3) != 0) && can_add(i);
        a[i]      = ($urandom_range(3) == 0) ? 32'hFFFF_FFFF : W'($urandom);
        b[i]      = ($urandom_range(1) == 0) ? W'($urandom_range(1)) : W'($urandom);
        cin[i]    = 1'($urandom_range(1));
        en_sum[i] = ($urandom_range(2) != 0) && (fifo_q[i].size() > 0);
        en_clr[i] = ($urandom_range(39) == 0);
      end
      tick();
    end
    idle();
    tick();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
